// File: rtl/mtx_pack_pkg.sv
// Shared types and slot mapping for the streaming matrix packer.
package mtx_pack_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_e;

  // Acceptance index k to flattened slot r*cols+c for either fill order.
  function automatic int slot_idx(input int k, input int rows, input int cols,
                                  input logic col_major);
    int r;
    int c;
    if (col_major) begin
      r = k % rows;
      c = k / rows;
    end else begin
      r = k / cols;
      c = k % cols;
    end
    return r * cols + c;
  endfunction

endpackage

// File: rtl/mtx_pack.sv
// Streaming matrix packer: element-serial input, whole-matrix output,
// with a fill buffer and an output register so the fill side keeps streaming.
module mtx_pack
  import mtx_pack_pkg::*;
#(
  parameter int   ELEM_W    = 8,
  parameter int   ROWS      = 2,
  parameter int   COLS      = 2,
  parameter bit   COL_MAJOR = 1'b0,
  localparam int  N         = ROWS * COLS,
  localparam int  CNT_W     = $clog2(N + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ELEM_W-1:0]     i_elem,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_flush,
  output logic [N*ELEM_W-1:0]   o_mtx,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_valid,
  input  logic                  i_ready
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  fill_state_e            state_q, state_d;
  logic [N*ELEM_W-1:0]    buf_q, buf_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N*ELEM_W-1:0]    mtx_q, mtx_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   valid_q, valid_d;

  logic                   accept;
  logic                   complete;
  logic                   out_free;
  logic                   load;
  int                     slot;
  logic [N*ELEM_W-1:0]    fill_buf;
  logic [CNT_W-1:0]       fill_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
      mtx_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      mtx_q   <= mtx_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // In FULL nothing is accepted, so fill_buf/fill_cnt are simply the held
  // matrix; the same load path serves both direct completion and FULL drain.
  always_comb begin
    accept   = i_valid && (state_q == FILL);
    slot     = slot_idx(int'(cnt_q), ROWS, COLS, COL_MAJOR);
    fill_buf = buf_q;
    if (accept) begin
      fill_buf[slot*ELEM_W +: ELEM_W] = i_elem;
    end
    fill_cnt = accept ? cnt_q + CNT_W'(1) : cnt_q;
    complete = (state_q == FILL) &&
               ((accept && (cnt_q == LAST)) || (i_flush && ((cnt_q != '0) || accept)));
    out_free = !valid_q || i_ready;
    load     = out_free && (complete || (state_q == FULL));

    state_d = state_q;
    case (state_q)
      FILL:    if (complete && !out_free) state_d = FULL;
      FULL:    if (out_free) state_d = FILL;
      default: state_d = FILL;
    endcase

    buf_d   = load ? '0 : fill_buf;
    cnt_d   = load ? '0 : fill_cnt;
    mtx_d   = load ? fill_buf : mtx_q;
    count_d = load ? fill_cnt : count_q;
    valid_d = load ? 1'b1 : (i_ready ? 1'b0 : valid_q);
  end

  always_comb begin
    o_ready = (state_q == FILL);
    o_mtx   = mtx_q;
    o_count = count_q;
    o_valid = valid_q;
  end

endmodule
